// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for mem_responder.
// FSM state enum, RW encodings, default widths. Optional: MEMRESP_PARITY_EN.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LAT        = 3;

endpackage

// File: rtl/mem_resp_if.sv
// mem_resp_if: cache <-> memory request bus (PLCK/RW/ADDR/WDATA in,
// DR/RDATA/BUSY out, PERR when MEMRESP_PARITY_EN). master=cache, slave=mem.
interface mem_resp_if
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              PLCK;
  logic              RW;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic              DR;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
`ifdef MEMRESP_PARITY_EN
  logic              PERR;
`endif

  modport master (
    output PLCK, RW, ADDR, WDATA,
`ifdef MEMRESP_PARITY_EN
    input  PERR,
`endif
    input  DR, RDATA, BUSY
  );

  modport slave (
    input  PLCK, RW, ADDR, WDATA,
`ifdef MEMRESP_PARITY_EN
    output PERR,
`endif
    output DR, RDATA, BUSY
  );

endinterface

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port storage, sync write, registered read.
// Ports: clk, rst_n, i_addr, i_we, i_re, i_wdata, o_rdata, o_perr (MEMRESP_PARITY_EN).
module mem_resp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [DATA_W-1:0] i_wdata,
`ifdef MEMRESP_PARITY_EN
  output logic              o_perr,
`endif
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef MEMRESP_PARITY_EN
  // Top bit holds even parity of the data bits.
  logic [DATA_W:0]   r_mem [0:DEPTH-1];
  logic              r_perr;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_addr] <= {^i_wdata, i_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
      r_perr  <= 1'b0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr][DATA_W-1:0];
      r_perr  <= ^r_mem[i_addr];
    end else begin
      o_rdata <= '0;
      r_perr  <= 1'b0;
    end
  end

  assign o_perr = r_perr;
`else
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
  end

  // Output reads zero whenever no beat is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_rdata <= '0;
    else if (i_re)
      o_rdata <= r_mem[i_addr];
    else
      o_rdata <= '0;
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder: main-memory responder, LAT wait states, wrapping line fill.
// Ports: SCLK, SRST (async low), bus (mem_resp_if.slave). Option: MEMRESP_PARITY_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LAT        = DEF_LAT
) (
  input logic       SCLK,
  input logic       SRST,
  mem_resp_if.slave bus
);

  localparam int CNT_W  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int BEAT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [ADDR_W-1:0] OFF_M = ADDR_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST  = BEAT_W'(LINE_WORDS - 1);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [BEAT_W-1:0] r_beat, w_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;

  logic              w_cap;
  logic              w_go;
  logic              w_go_rw;
  logic [ADDR_W-1:0] w_go_addr;
  logic [DATA_W-1:0] w_go_wdata;
  logic              w_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_maddr;
  logic [DATA_W-1:0] w_mwdata;

  // Offset wraps inside the aligned line; line base is fixed.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0] a,
    input logic [BEAT_W-1:0] j
  );
    return (a & ~OFF_M) | ((a + ADDR_W'(j)) & OFF_M);
  endfunction

  always_comb begin
    w_next     = r_state;
    w_cnt      = r_cnt;
    w_beat     = r_beat;
    w_cap      = 1'b0;
    w_go       = 1'b0;
    w_go_rw    = r_rw;
    w_go_addr  = r_addr;
    w_go_wdata = r_wdata;
    w_re       = 1'b0;
    w_we       = 1'b0;
    w_maddr    = r_addr;
    w_mwdata   = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (bus.PLCK) begin
          w_cap = 1'b1;
          if (LAT == 0) begin
            w_go       = 1'b1;
            w_go_rw    = bus.RW;
            w_go_addr  = bus.ADDR;
            w_go_wdata = bus.WDATA;
          end else begin
            w_next = WAIT;
            w_cnt  = CNT_W'(LAT);
          end
        end
      end
      WAIT: begin
        w_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1))
          w_go = 1'b1;
      end
      XFER: begin
        if (r_rw == RW_READ && r_beat != LAST) begin
          w_beat  = r_beat + BEAT_W'(1);
          w_re    = 1'b1;
          w_maddr = beat_addr(r_addr, w_beat);
        end else begin
          w_next = DONE;
        end
      end
      DONE: w_next = IDLE;
    endcase
    // Entry into XFER: issue beat 0 or commit the write.
    if (w_go) begin
      w_next   = XFER;
      w_beat   = '0;
      w_maddr  = w_go_addr;
      w_mwdata = w_go_wdata;
      if (w_go_rw == RW_READ)
        w_re = 1'b1;
      else
        w_we = 1'b1;
    end
  end

  always_ff @(posedge SCLK or negedge SRST) begin
    if (!SRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= RW_WRITE;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_beat  <= w_beat;
      if (w_cap) begin
        r_addr  <= bus.ADDR;
        r_wdata <= bus.WDATA;
        r_rw    <= bus.RW;
      end
    end
  end

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (SCLK),
    .rst_n   (SRST),
    .i_addr  (w_maddr),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_wdata (w_mwdata),
`ifdef MEMRESP_PARITY_EN
    .o_perr  (bus.PERR),
`endif
    .o_rdata (bus.RDATA)
  );

  assign bus.DR   = (r_state == XFER);
  assign bus.BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table + scoreboard bench for mem_responder.
// Two DUTs: LAT=3 (d3) and LAT=0 (d0). Option: MEMRESP_PARITY_EN.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic SCLK = 1'b0;
  logic SRST = 1'b0;
  int   cyc  = 0;

  always #5 SCLK = ~SCLK;
  always @(posedge SCLK) cyc <= cyc + 1;

  mem_resp_if #(.ADDR_W(8), .DATA_W(32)) b3 ();
  mem_resp_if #(.ADDR_W(8), .DATA_W(32)) b0 ();

  mem_responder #(
    .ADDR_W(8), .DATA_W(32), .LINE_WORDS(4), .LAT(3)
  ) d3 (.SCLK(SCLK), .SRST(SRST), .bus(b3));

  mem_responder #(
    .ADDR_W(8), .DATA_W(32), .LINE_WORDS(4), .LAT(0)
  ) d0 (.SCLK(SCLK), .SRST(SRST), .bus(b0));

  typedef struct {
    logic [31:0] d;
    int          c;
    logic        p;
  } sb_t;

  typedef struct {
    bit          w;
    logic        rw;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e0, e1, e2, e3;
  } vec_t;

  sb_t  q3[$];
  sb_t  q0[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   sb_off = 0;
  bit   ok;
  int   k1, k2, cnt;
  bit   seen_low;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, a, e, cyc);
    end
  endtask

  function automatic vec_t mk(input bit w, input logic rw,
      input logic [7:0] a, input logic [31:0] d,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.w = w; v.rw = rw; v.a = a; v.d = d;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic drive(input bit w, input logic pl, input logic rw,
                       input logic [7:0] a, input logic [31:0] d);
    if (w) begin
      b0.PLCK = pl; b0.RW = rw; b0.ADDR = a; b0.WDATA = d;
    end else begin
      b3.PLCK = pl; b3.RW = rw; b3.ADDR = a; b3.WDATA = d;
    end
  endtask

  task automatic push(input bit w, input logic rw, input int k,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] e2, input logic [31:0] e3,
      input logic [3:0] pe);
    logic [31:0] ex[4];
    sb_t s;
    int lat;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    lat = w ? 0 : 3;
    for (int j = 0; j < (rw ? 4 : 1); j++) begin
      s.d = rw ? ex[j] : 32'h0;
      s.c = k + lat + j;
      s.p = rw ? pe[j] : 1'b0;
      if (w) q0.push_back(s);
      else   q3.push_back(s);
    end
  endtask

  // One request; returns at a negedge once the DUT is idle again.
  task automatic issue(input bit w, input logic rw,
      input logic [7:0] a, input logic [31:0] d,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] e2, input logic [31:0] e3,
      input logic [3:0] pe);
    int k, done_c;
    bit fin;
    logic busy, dr;
    drive(w, 1'b1, rw, a, d);
    @(posedge SCLK); #1;
    k = cyc;
    drive(w, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("busy_acc", w ? b0.BUSY : b3.BUSY, 1);
    push(w, rw, k, e0, e1, e2, e3, pe);
    done_c = k + (w ? 0 : 3) + (rw ? 4 : 1);
    fin = 0;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge SCLK);
      busy = w ? b0.BUSY : b3.BUSY;
      dr   = w ? b0.DR : b3.DR;
      if (cyc == done_c) begin
        chk("done_dr", dr, 0);
        chk("done_busy", busy, 1);
      end
      if (!busy) fin = 1;
    end
    chk("complete", fin, 1);
  endtask

  always @(negedge SCLK) begin
    if (SRST && !sb_off && b3.DR) begin
      sb_t e;
      chk("d3_sb_nonempty", 32'(q3.size() != 0), 1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("d3_rdata", b3.RDATA, e.d);
        chk("d3_dr_cycle", 32'(cyc), 32'(e.c));
`ifdef MEMRESP_PARITY_EN
        chk("d3_perr", b3.PERR, e.p);
`endif
      end
    end
  end

  always @(negedge SCLK) begin
    if (SRST && b0.DR) begin
      sb_t e;
      chk("d0_sb_nonempty", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("d0_rdata", b0.RDATA, e.d);
        chk("d0_dr_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 8'h0, 32'h0);
    drive(1, 0, 0, 8'h0, 32'h0);

    tbl.push_back(mk(0, RW_WRITE, 8'h40, 32'hA0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h41, 32'hA1, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h42, 32'hA2, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h43, 32'hA3, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_READ, 8'h42, 0,
                     32'hA2, 32'hA3, 32'hA0, 32'hA1));
    tbl.push_back(mk(0, RW_WRITE, 8'h20, 32'h20202020, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h21, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h22, 32'h22222222, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h23, 32'h23232323, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_READ, 8'h21, 0,
                     32'hDEADBEEF, 32'h22222222,
                     32'h23232323, 32'h20202020));
    tbl.push_back(mk(0, RW_READ, 8'h40, 0,
                     32'hA0, 32'hA1, 32'hA2, 32'hA3));
    tbl.push_back(mk(0, RW_READ, 8'h43, 0,
                     32'hA3, 32'hA0, 32'hA1, 32'hA2));
    tbl.push_back(mk(0, RW_WRITE, 8'h30, 32'h30303030, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h31, 32'h31313131, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h32, 32'h32323232, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_WRITE, 8'h33, 32'h33333333, 0, 0, 0, 0));
    tbl.push_back(mk(1, RW_WRITE, 8'h50, 32'h50505050, 0, 0, 0, 0));
    tbl.push_back(mk(1, RW_WRITE, 8'h51, 32'h51515151, 0, 0, 0, 0));
    tbl.push_back(mk(1, RW_WRITE, 8'h52, 32'h52525252, 0, 0, 0, 0));
    tbl.push_back(mk(1, RW_WRITE, 8'h53, 32'h53535353, 0, 0, 0, 0));
    tbl.push_back(mk(1, RW_READ, 8'h53, 0,
                     32'h53535353, 32'h50505050,
                     32'h51515151, 32'h52525252));
    tbl.push_back(mk(0, RW_WRITE, 8'h21, 32'hCAFEF00D, 0, 0, 0, 0));
    tbl.push_back(mk(0, RW_READ, 8'h20, 0,
                     32'h20202020, 32'hCAFEF00D,
                     32'h22222222, 32'h23232323));

    #2;
    chk("rst_dr3", b3.DR, 0);
    chk("rst_busy3", b3.BUSY, 0);
    chk("rst_rdata3", b3.RDATA, 0);
    chk("rst_dr0", b0.DR, 0);
    chk("rst_busy0", b0.BUSY, 0);
    #20;
    SRST = 1'b1;
    @(negedge SCLK);

    foreach (tbl[i])
      issue(tbl[i].w, tbl[i].rw, tbl[i].a, tbl[i].d,
            tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3, 4'b0);

    // PLCK held high across two reads: second accepted at k1+9.
    drive(0, 1'b1, RW_READ, 8'h40, 32'h0);
    @(posedge SCLK); #1;
    k1 = cyc;
    push(0, RW_READ, k1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0);
    push(0, RW_READ, k1 + 9, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0);
    seen_low = 0;
    k2 = -1;
    for (int t = 0; t < 30 && k2 < 0; t++) begin
      @(negedge SCLK);
      if (!b3.BUSY) seen_low = 1;
      else if (seen_low) k2 = cyc;
    end
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("held_spacing", 32'(k2 - k1), 9);
    ok = 0;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge SCLK);
      if (!b3.BUSY) ok = 1;
    end
    chk("held_complete", ok, 1);

    // Reset mid-WAIT of a read at 0x12.
    drive(0, 1'b1, RW_READ, 8'h12, 32'h0);
    @(posedge SCLK); #1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(posedge SCLK); #1;
    chk("wait_busy", b3.BUSY, 1);
    SRST = 1'b0;
    #1;
    chk("rstw_dr", b3.DR, 0);
    chk("rstw_busy", b3.BUSY, 0);
    chk("rstw_rdata", b3.RDATA, 0);
    #2;
    SRST = 1'b1;
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge SCLK);
      if (b3.DR) cnt++;
    end
    chk("no_dr_after_rst", cnt, 0);

    // Reset in the middle of a burst.
    sb_off = 1;
    drive(0, 1'b1, RW_READ, 8'h41, 32'h0);
    @(posedge SCLK); #1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge SCLK);
      if (b3.DR) ok = 1;
    end
    chk("rb_dr_seen", ok, 1);
    chk("rb_beat0", b3.RDATA, 32'hA1);
    @(posedge SCLK); #1;
    chk("rb_beat1", b3.RDATA, 32'hA2);
    SRST = 1'b0;
    #1;
    chk("rstb_dr", b3.DR, 0);
    chk("rstb_busy", b3.BUSY, 0);
    chk("rstb_rdata", b3.RDATA, 0);
    #2;
    SRST = 1'b1;

    // Uncommitted write to 0x30 is dropped by reset.
    @(negedge SCLK);
    drive(0, 1'b1, RW_WRITE, 8'h30, 32'hBAD0BAD0);
    @(posedge SCLK); #1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(posedge SCLK); #1;
    SRST = 1'b0;
    #2;
    SRST = 1'b1;
    sb_off = 0;
    @(negedge SCLK);
    issue(0, RW_READ, 8'h30, 0, 32'h30303030, 32'h31313131,
          32'h32323232, 32'h33333333, 4'b0);
    issue(0, RW_READ, 8'h22, 0, 32'h22222222, 32'h23232323,
          32'h20202020, 32'hCAFEF00D, 4'b0);
    issue(1, RW_READ, 8'h50, 0, 32'h50505050, 32'h51515151,
          32'h52525252, 32'h53535353, 4'b0);

`ifdef MEMRESP_PARITY_EN
    issue(0, RW_WRITE, 8'h04, 32'h00000004, 0, 0, 0, 0, 4'b0);
    issue(0, RW_WRITE, 8'h05, 32'h00000055, 0, 0, 0, 0, 4'b0);
    issue(0, RW_WRITE, 8'h06, 32'h00000006, 0, 0, 0, 0, 4'b0);
    issue(0, RW_WRITE, 8'h07, 32'h00000007, 0, 0, 0, 0, 4'b0);
    d3.u_array.r_mem[5][0] = ~d3.u_array.r_mem[5][0];
    issue(0, RW_READ, 8'h05, 0, 32'h00000054, 32'h00000006,
          32'h00000007, 32'h00000004, 4'b0001);
`endif

    repeat (3) @(negedge SCLK);
    chk("q3_empty", q3.size(), 0);
    chk("q0_empty", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
